// File: rtl/fetch_pc_sequencer_if.sv
// Fetch sequencer bundle: PC register loop, instruction-memory request/response, downstream instruction, redirect.
// Latency: none, this is wiring only.
// Backpressure: IReqReady stalls requests, InstrReady holds the presented instruction.
// With FETCH_MISALIGN_CHECK_EN defined, the bundle also carries MisalignFault.
interface fetch_pc_sequencer_if #(
    parameter int BITS_SIZE = 32
);
    logic [BITS_SIZE-1:0] PCResult;
    logic [BITS_SIZE-1:0] PCNext;
    logic                 IReqValid;
    logic [BITS_SIZE-1:0] IReqAddr;
    logic                 IReqReady;
    logic                 IRspValid;
    logic [BITS_SIZE-1:0] IRspData;
    logic                 InstrValid;
    logic [BITS_SIZE-1:0] InstrData;
    logic [BITS_SIZE-1:0] InstrPC;
    logic                 InstrReady;
    logic                 RedirectValid;
    logic [BITS_SIZE-1:0] RedirectTarget;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic                 MisalignFault;

    modport master (
        input  PCResult, IReqReady, IRspValid, IRspData, InstrReady, RedirectValid, RedirectTarget,
        output PCNext, IReqValid, IReqAddr, InstrValid, InstrData, InstrPC, MisalignFault
    );
    modport slave (
        output PCResult, IReqReady, IRspValid, IRspData, InstrReady, RedirectValid, RedirectTarget,
        input  PCNext, IReqValid, IReqAddr, InstrValid, InstrData, InstrPC, MisalignFault
    );
`else
    modport master (
        input  PCResult, IReqReady, IRspValid, IRspData, InstrReady, RedirectValid, RedirectTarget,
        output PCNext, IReqValid, IReqAddr, InstrValid, InstrData, InstrPC
    );
    modport slave (
        output PCResult, IReqReady, IRspValid, IRspData, InstrReady, RedirectValid, RedirectTarget,
        input  PCNext, IReqValid, IReqAddr, InstrValid, InstrData, InstrPC
    );
`endif
endinterface

// File: rtl/fetch_pc_sequencer.sv
// Fetch PC sequencer: drives the PC register, issues one fetch per PC, presents instructions, handles redirects.
// Latency: one instruction per 3 cycles at best (REQ, WAIT, HOLD); PCNext is combinational.
// Backpressure: IReqReady low holds the PC in REQ; InstrReady low holds the instruction in HOLD.
// Optional macro FETCH_MISALIGN_CHECK_EN: aligns redirect targets to 4 bytes and raises sticky MisalignFault.
module fetch_pc_sequencer #(
    parameter int                   BITS_SIZE    = 32,
    parameter logic [BITS_SIZE-1:0] RESET_VECTOR = '0,
    parameter int                   PC_STEP      = 4
) (
    input  logic                  Clk,
    input  logic                  ResetN,
    fetch_pc_sequencer_if.master  bus
);

    localparam logic [BITS_SIZE-1:0] STEP = BITS_SIZE'(PC_STEP);

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic                 squash_q;
    logic                 squash_d;
    logic                 accept;
    logic                 capture;
    logic                 req_valid;
    logic [BITS_SIZE-1:0] pc_next;
    logic [BITS_SIZE-1:0] redirect_pc;
    logic [BITS_SIZE-1:0] fetch_pc_q;
    logic                 instr_valid_q;
    logic [BITS_SIZE-1:0] instr_data_q;
    logic [BITS_SIZE-1:0] instr_pc_q;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic misalign_q;

    // Low address bits are dropped so the PC never leaves word alignment.
    assign redirect_pc = {bus.RedirectTarget[BITS_SIZE-1:2], 2'b00};

    // Any unaligned redirect latches the fault until reset.
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            misalign_q <= 1'b0;
        end else if (bus.RedirectValid && (bus.RedirectTarget[1:0] != 2'b00)) begin
            misalign_q <= 1'b1;
        end
    end

    assign bus.MisalignFault = misalign_q;
`else
    assign redirect_pc = bus.RedirectTarget;
`endif

    // State register.
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            state_q <= ST_REQ;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, PC selection and handshake decisions; a redirect overrides everything else.
    always_comb begin
        state_d   = state_q;
        squash_d  = squash_q;
        accept    = 1'b0;
        capture   = 1'b0;
        req_valid = 1'b0;
        pc_next   = bus.PCResult;
        case (state_q)
            ST_REQ: begin
                req_valid = 1'b1;
                if (bus.RedirectValid) begin
                    // The request this cycle carries a stale PC; it is never counted as accepted.
                    pc_next = redirect_pc;
                end else if (bus.IReqReady) begin
                    accept  = 1'b1;
                    pc_next = bus.PCResult + STEP;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bus.RedirectValid) begin
                    pc_next = redirect_pc;
                    if (bus.IRspValid) begin
                        // Response for the old path arrives right now: drop it, nothing left to squash.
                        squash_d = 1'b0;
                        state_d  = ST_REQ;
                    end else begin
                        squash_d = 1'b1;
                    end
                end else if (bus.IRspValid) begin
                    if (squash_q) begin
                        squash_d = 1'b0;
                        state_d  = ST_REQ;
                    end else begin
                        capture = 1'b1;
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (bus.RedirectValid) begin
                    // Held instruction is wrong-path; discard it even if the consumer is ready.
                    pc_next = redirect_pc;
                    state_d = ST_REQ;
                end else if (bus.InstrReady) begin
                    state_d = ST_REQ;
                end
            end
            default: begin
                state_d = ST_REQ;
            end
        endcase
    end

    // Squash flag, the PC of the outstanding fetch, and the held instruction.
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            squash_q      <= 1'b0;
            fetch_pc_q    <= '0;
            instr_valid_q <= 1'b0;
            instr_data_q  <= '0;
            instr_pc_q    <= '0;
        end else begin
            squash_q      <= squash_d;
            instr_valid_q <= (state_d == ST_HOLD);
            if (accept) begin
                fetch_pc_q <= bus.PCResult;
            end
            if (capture) begin
                instr_data_q <= bus.IRspData;
                instr_pc_q   <= fetch_pc_q;
            end
        end
    end

    // Reset gating keeps the request line quiet and the PC pinned while ResetN is low.
    assign bus.IReqValid  = ResetN & req_valid;
    assign bus.IReqAddr   = bus.PCResult;
    assign bus.PCNext     = ResetN ? pc_next : RESET_VECTOR;
    assign bus.InstrValid = instr_valid_q;
    assign bus.InstrData  = instr_data_q;
    assign bus.InstrPC    = instr_pc_q;

endmodule

// File: doc/fetch_pc_sequencer.md
Name: fetch_pc_sequencer

Overview:
- Drives the ProgramCounter register's next-value input, PCNext, and consumes its current value, PCResult.
- Issues one instruction-memory fetch per PC value over a valid/ready request channel and accepts the response.
- Presents each instruction downstream with a valid/ready handshake.
- Redirects the PC on branch/jump and squashes any fetch already in flight.

Parameters:
- BITS_SIZE, 32: width of PC, addresses and instruction data.
- RESET_VECTOR, 0: PC value driven on PCNext during and after reset.
- PC_STEP, 4: sequential PC increment, in bytes.

Ports:
- Clk  in  1  rising-edge clock.
- ResetN  in  1  asynchronous, active-low reset.
- PCResult  in  BITS_SIZE  current PC from the ProgramCounter register.
- PCNext  out  BITS_SIZE  next PC to the ProgramCounter register.
- IReqValid  out  1  fetch request valid.
- IReqAddr  out  BITS_SIZE  fetch address.
- IReqReady  in  1  memory accepts the request.
- IRspValid  in  1  memory response valid, one cycle per accepted request.
- IRspData  in  BITS_SIZE  fetched instruction.
- InstrValid  out  1  instruction available downstream.
- InstrData  out  BITS_SIZE  held instruction.
- InstrPC  out  BITS_SIZE  PC of the held instruction.
- InstrReady  in  1  downstream consumes the instruction.
- RedirectValid  in  1  one-cycle branch/jump redirect pulse.
- RedirectTarget  in  BITS_SIZE  redirect destination.

Behaviour:
- Reset:
  - While ResetN is low: state = REQ, IReqValid = 0, InstrValid = 0, InstrData = 0, InstrPC = 0, Squash = 0, PCNext = RESET_VECTOR.
  - IReqValid rises on the first cycle after ResetN deasserts.
- State REQ:
  - IReqValid = 1, IReqAddr = PCResult.
  - If IReqReady: latch FetchPC = PCResult, PCNext = PCResult + PC_STEP, go to WAIT.
  - Otherwise PCNext = PCResult (hold).
- State WAIT:
  - IReqValid = 0, PCNext = PCResult.
  - On IRspValid with Squash = 0: capture InstrData = IRspData and InstrPC = FetchPC, assert InstrValid, go to HOLD.
  - On IRspValid with Squash = 1: drop the response, clear Squash, go to REQ.
- State HOLD:
  - InstrValid = 1, PCNext = PCResult.
  - On InstrReady: deassert InstrValid and go to REQ.
  - The same-cycle handoff REQ->WAIT is not permitted; the next request issues the following cycle.
- Redirect (highest priority, any state):
  - PCNext = RedirectTarget that cycle.
  - In REQ: the request is not treated as accepted even if IReqReady = 1, so the memory must ignore that cycle's request. Remain in REQ.
  - In WAIT: set Squash, remain in WAIT.
  - In HOLD: drop InstrValid immediately (next edge) and go to REQ. InstrReady in the same cycle is ignored; the instruction is discarded.
- Redirect in the same cycle as IRspValid in WAIT: the response is dropped, go to REQ, Squash stays 0.
- Arithmetic: PC + PC_STEP wraps modulo 2^BITS_SIZE (0xFFFFFFFC + 4 = 0x00000000); no flag is raised.
- Maximum throughput: one instruction per 3 cycles (REQ, WAIT, HOLD) with memory and consumer always ready.
- Asynchronous reset mid-operation returns to the reset values immediately; any in-flight response is ignored.
- The ProgramCounter register lags PCNext by one edge, so PCResult always reflects the previous cycle's PCNext.

Optional Feature:
- Macro FETCH_MISALIGN_CHECK_EN.
- Defined:
  - Adds output MisalignFault (1 bit, reset 0).
  - A redirect whose RedirectTarget[1:0] != 0 sets MisalignFault, sticky until reset.
  - PCNext = {RedirectTarget[BITS_SIZE-1:2], 2'b00}; the aligned address is used.
- Not defined:
  - No MisalignFault port.
  - RedirectTarget passes to PCNext unmodified.

Test Plan:
- Reset then free run, IReqReady = 1, IRspValid one cycle after acceptance, InstrReady = 1, RESET_VECTOR = 0 -> InstrPC sequence 0x0, 0x4, 0x8, one InstrValid pulse every 3 cycles, InstrData equal to the memory model contents.
- IReqReady held 0 for 5 cycles in REQ -> IReqAddr and PCNext stay at 0x8; no PC advance; acceptance on cycle 6.
- InstrReady held 0 for 4 cycles in HOLD -> InstrValid, InstrData and InstrPC stable; no new IReqValid until consumption.
- RedirectValid = 1 with target 0x100 while in WAIT for fetch of 0x10 -> response for 0x10 never appears on InstrValid; next InstrPC = 0x100.
- PC = 0xFFFFFFFC accepted -> PCNext = 0x00000000; ResetN pulsed low mid-WAIT -> IReqValid = 0, InstrValid = 0, PCNext = RESET_VECTOR asynchronously.
- With FETCH_MISALIGN_CHECK_EN, redirect to 0x102 -> PCNext = 0x100, MisalignFault = 1 and sticky; without the macro -> PCNext = 0x102.
